// File: rtl/branch_predictor_core.sv
// rtl/branch_predictor_core.sv - 2-bit saturating-counter branch predictor with statistics
//
// Resolves completed branches from the predictor input latch and predicts each one from a
// table of 2-bit saturating counters indexed by the low address bits. The result is reported
// one cycle after the event, and the table entry is trained at the event edge.
// Ports:
//   i_clock, i_reset               clock; synchronous active-high reset
//   i_latched_branch[13:0]         instruction word; [13:11] opcode, [10:0] target
//   i_latched_branch_addr[10:0]    instruction address; low IDX_BITS select the table entry
//   i_latched_W[15:0], i_latched_CY  W register and carry flag at execution
//   i_latched_exec_done            instruction finished this cycle
//   o_ready                        table initialised, events accepted
//   o_pred_valid                   one-cycle pulse qualifying the result outputs
//   o_pred_taken, o_actual_taken, o_mispredict, o_pred_target[10:0]  result of last event
//   o_branch_count, o_mispredict_count  saturating statistics
module branch_predictor_core #(
   parameter int IDX_BITS = 4,
   parameter int CNT_W    = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [13:0]      i_latched_branch,
   input  logic [10:0]      i_latched_branch_addr,
   input  logic [15:0]      i_latched_W,
   input  logic             i_latched_CY,
   input  logic             i_latched_exec_done,
   output logic             o_ready,
   output logic             o_pred_valid,
   output logic             o_pred_taken,
   output logic             o_actual_taken,
   output logic             o_mispredict,
   output logic [10:0]      o_pred_target,
   output logic [CNT_W-1:0] o_branch_count,
   output logic [CNT_W-1:0] o_mispredict_count
);

   localparam int ENTRIES = 1 << IDX_BITS;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [IDX_BITS-1:0]   r_init_idx;
   logic [1:0]            r_table [ENTRIES];

   logic [2:0]            w_opcode;
   logic                  w_is_branch;
   logic                  w_taken;
   logic                  w_event;
   logic [IDX_BITS-1:0]   w_idx;
   logic [1:0]            w_ctr;
   logic [1:0]            w_ctr_next;
   logic                  w_mispredict;

   // State register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= ST_INIT;
         r_init_idx <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_INIT) begin
            r_init_idx <= r_init_idx + 1'b1;
         end
      end
   end

   // Next state: INIT walks every entry once, RUN is left only through reset
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT: if (r_init_idx == IDX_BITS'(ENTRIES - 1)) w_state_next = ST_RUN;
         ST_RUN:  w_state_next = ST_RUN;
         default: w_state_next = ST_INIT;
      endcase
   end

   assign o_ready = (r_state == ST_RUN);

   // Decode and resolve
   assign w_opcode = i_latched_branch[13:11];

   always_comb begin
      w_is_branch = 1'b1;
      w_taken     = 1'b0;
      case (w_opcode)
         3'b101:  w_taken = (i_latched_W == 16'h0000);
         3'b110:  w_taken = i_latched_CY;
         3'b111:  w_taken = 1'b1;
         default: w_is_branch = 1'b0;
      endcase
   end

   assign w_event = (r_state == ST_RUN) && i_latched_exec_done && w_is_branch;
   assign w_idx   = i_latched_branch_addr[IDX_BITS-1:0];
   // Combinational read: an event on the cycle after a write to the same entry sees the new value
   assign w_ctr   = r_table[w_idx];

   always_comb begin
      w_ctr_next = w_ctr;
      if (w_taken) begin
         if (w_ctr != 2'b11) w_ctr_next = w_ctr + 2'b01;
      end else begin
         if (w_ctr != 2'b00) w_ctr_next = w_ctr - 2'b01;
      end
   end

   assign w_mispredict = w_ctr[1] ^ w_taken;

   // Table has no reset of its own; INIT rewrites every entry before any event can read it
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         if (r_state == ST_INIT) begin
            r_table[r_init_idx] <= 2'b01;
         end else if (w_event) begin
            r_table[w_idx] <= w_ctr_next;
         end
      end
   end

   // Result registers and statistics
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_pred_valid       <= 1'b0;
         o_pred_taken       <= 1'b0;
         o_actual_taken     <= 1'b0;
         o_mispredict       <= 1'b0;
         o_pred_target      <= '0;
         o_branch_count     <= '0;
         o_mispredict_count <= '0;
      end else begin
         o_pred_valid <= w_event;
         if (w_event) begin
            o_pred_taken   <= w_ctr[1];
            o_actual_taken <= w_taken;
            o_mispredict   <= w_mispredict;
            o_pred_target  <= i_latched_branch[10:0];
            if (o_branch_count != {CNT_W{1'b1}}) begin
               o_branch_count <= o_branch_count + 1'b1;
            end
            if (w_mispredict && (o_mispredict_count != {CNT_W{1'b1}})) begin
               o_mispredict_count <= o_mispredict_count + 1'b1;
            end
         end
      end
   end

endmodule
